// File: rtl/lcd_dma_arbiter_pkg.sv
// Shared types and widths for the LCD DMA read arbiter.
// Optional build macro: LCD_DMA_ARB_FIXED_PRIO_EN (fixed priority instead of round-robin).
package lcd_dma_pkg;

    localparam int DMA_ADDR_W = 30;
    localparam int DMA_DATA_W = 32;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        ISSUE     = 2'd1,
        WAIT_DATA = 2'd2
    } state_e;

endpackage

// File: rtl/lcd_dma_arbiter_if.sv
// Requester-side and DMA-side handshake bundle of the LCD DMA read arbiter.
// Optional build macro: LCD_DMA_ARB_FIXED_PRIO_EN (does not affect this file).
interface lcd_dma_arbiter_if
    import lcd_dma_pkg::*;
#(
    parameter int NUM_REQ = 2
);

    logic [NUM_REQ-1:0]            REQ_START;
    logic [NUM_REQ*DMA_ADDR_W-1:0] REQ_ADDR;
    logic [NUM_REQ-1:0]            REQ_READY;
    logic [DMA_DATA_W-1:0]         REQ_RD_DATA;
    logic [NUM_REQ-1:0]            REQ_RD_DATA_VALID;

    logic [DMA_ADDR_W-1:0]         DMA_RD_ADDR;
    logic                          DMA_START;
    logic                          DMA_READY;
    logic [DMA_DATA_W-1:0]         DMA_RD_DATA;
    logic                          DMA_RD_DATA_VALID;

    // Arbiter side
    modport slave (
        input  REQ_START, REQ_ADDR, DMA_READY, DMA_RD_DATA, DMA_RD_DATA_VALID,
        output REQ_READY, REQ_RD_DATA, REQ_RD_DATA_VALID, DMA_RD_ADDR, DMA_START
    );

    // Requesters plus DMA engine side
    modport master (
        output REQ_START, REQ_ADDR, DMA_READY, DMA_RD_DATA, DMA_RD_DATA_VALID,
        input  REQ_READY, REQ_RD_DATA, REQ_RD_DATA_VALID, DMA_RD_ADDR, DMA_START
    );

endinterface

// File: rtl/lcd_dma_arbiter_rr_picker.sv
// Combinational rotating priority encoder: lowest requesting index at or after ptr_i wins.
// With LCD_DMA_ARB_FIXED_PRIO_EN defined the search always starts at index 0.
module lcd_dma_rr_picker #(
    parameter int NUM_REQ = 2,
    parameter int PW      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [PW-1:0]      ptr_i,
    output logic               any_o,
    output logic [PW-1:0]      idx_o
);

    logic [PW-1:0] start;
    logic [PW-1:0] cand;
    int            j;

`ifdef LCD_DMA_ARB_FIXED_PRIO_EN
    logic unused_ptr;
    assign unused_ptr = ^ptr_i;
    assign start      = '0;
`else
    assign start      = ptr_i;
`endif

    always_comb begin
        any_o = 1'b0;
        idx_o = '0;
        j     = 0;
        cand  = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            j = int'(start) + k;
            if (j >= NUM_REQ) j = j - NUM_REQ;
            cand = PW'(j);
            if (!any_o && req_i[cand]) begin
                any_o = 1'b1;
                idx_o = cand;
            end
        end
    end

endmodule

// File: rtl/lcd_dma_arbiter.sv
// Arbitrates NUM_REQ burst-read requesters onto one shared DMA; one burst in flight at a time.
// Optional build macro: LCD_DMA_ARB_FIXED_PRIO_EN (fixed priority, index 0 highest).
module lcd_dma_arbiter
    import lcd_dma_pkg::*;
#(
    parameter int NUM_REQ    = 2,
    parameter int BURST_SIZE = 8
) (
    input  logic               CLK,
    input  logic               RESET_N,
    lcd_dma_arbiter_if.slave   bus,
    output logic               STRAY_BEAT
);

    localparam int PW = (NUM_REQ > 1)    ? $clog2(NUM_REQ)    : 1;
    localparam int CW = (BURST_SIZE > 1) ? $clog2(BURST_SIZE) : 1;

    state_e                state_q, state_d;
    logic [NUM_REQ-1:0]    pending_q, pending_d;
    logic [NUM_REQ-1:0]    ready_q, ready_d;
    logic [PW-1:0]         owner_q, owner_d;
    logic [PW-1:0]         ptr_q, ptr_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [DMA_ADDR_W-1:0] dma_addr_q, dma_addr_d;
    logic                  dma_start_q, dma_start_d;
    logic [DMA_DATA_W-1:0] rd_data_q, rd_data_d;
    logic [NUM_REQ-1:0]    rd_vld_q, rd_vld_d;
    logic                  stray_q, stray_d;

    logic [DMA_ADDR_W-1:0] addr_q [NUM_REQ];
    logic [NUM_REQ-1:0]    accept;
    logic                  gnt_any;
    logic [PW-1:0]         gnt_idx;

    assign accept = bus.REQ_START & ready_q;

    lcd_dma_rr_picker #(
        .NUM_REQ (NUM_REQ),
        .PW      (PW)
    ) u_picker (
        .req_i (pending_q),
        .ptr_i (ptr_q),
        .any_o (gnt_any),
        .idx_o (gnt_idx)
    );

    always_comb begin
        state_d     = state_q;
        pending_d   = pending_q;
        owner_d     = owner_q;
        ptr_d       = ptr_q;
        cnt_d       = cnt_q;
        dma_addr_d  = dma_addr_q;
        dma_start_d = 1'b0;
        rd_data_d   = rd_data_q;
        rd_vld_d    = '0;
        stray_d     = stray_q;
        ready_d     = ready_q;

        case (state_q)
            IDLE: begin
                if (bus.DMA_RD_DATA_VALID) stray_d = 1'b1;
                if (gnt_any && bus.DMA_READY) begin
                    owner_d            = gnt_idx;
                    pending_d[gnt_idx] = 1'b0;
                    dma_addr_d         = addr_q[gnt_idx];
                    dma_start_d        = 1'b1;
                    state_d            = ISSUE;
                end
            end
            ISSUE: begin
                if (bus.DMA_RD_DATA_VALID) stray_d = 1'b1;
                cnt_d   = CW'(BURST_SIZE - 1);
                state_d = WAIT_DATA;
            end
            WAIT_DATA: begin
                if (bus.DMA_RD_DATA_VALID) begin
                    rd_data_d         = bus.DMA_RD_DATA;
                    rd_vld_d[owner_q] = 1'b1;
                    if (cnt_q == '0) begin
                        state_d = IDLE;
                        ptr_d   = (owner_q == PW'(NUM_REQ - 1)) ? '0 : owner_q + PW'(1);
                    end else begin
                        cnt_d = cnt_q - CW'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // Only requesters whose ready was visible may queue; the winner cannot be re-set here
        pending_d = pending_d | accept;

        // Ready is derived from next-state so it drops in the same edge a request is taken
        for (int i = 0; i < NUM_REQ; i++) begin
            ready_d[i] = ~pending_d[i] & ~((state_d == WAIT_DATA) && (owner_d == PW'(i)));
        end
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q     <= IDLE;
            pending_q   <= '0;
            ready_q     <= '1;
            owner_q     <= '0;
            ptr_q       <= '0;
            cnt_q       <= '0;
            dma_addr_q  <= '0;
            dma_start_q <= 1'b0;
            rd_data_q   <= '0;
            rd_vld_q    <= '0;
            stray_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            pending_q   <= pending_d;
            ready_q     <= ready_d;
            owner_q     <= owner_d;
            ptr_q       <= ptr_d;
            cnt_q       <= cnt_d;
            dma_addr_q  <= dma_addr_d;
            dma_start_q <= dma_start_d;
            rd_data_q   <= rd_data_d;
            rd_vld_q    <= rd_vld_d;
            stray_q     <= stray_d;
        end
    end

    // Address registers are only meaningful while pending, so they carry no reset
    always_ff @(posedge CLK) begin
        for (int i = 0; i < NUM_REQ; i++) begin
            if (accept[i]) addr_q[i] <= bus.REQ_ADDR[i*DMA_ADDR_W +: DMA_ADDR_W];
        end
    end

    assign bus.REQ_READY         = ready_q;
    assign bus.REQ_RD_DATA       = rd_data_q;
    assign bus.REQ_RD_DATA_VALID = rd_vld_q;
    assign bus.DMA_RD_ADDR       = dma_addr_q;
    assign bus.DMA_START         = dma_start_q;
    assign STRAY_BEAT            = stray_q;

endmodule
